// File: rtl/mdma_ram_arb_ctl.sv
// MDMA context RAM arbiter: zero-init sweep, then round-robin A/B access
// with in-order read return and saturating ECC error counters.
module mdma_ram_arb_ctl #(
  parameter int DW     = 76,
  parameter int AW     = 8,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_vld,
  output logic [1:0]       req_rdy,
  input  logic [1:0]       req_we,
  input  logic [AW-1:0]    req_adr_a,
  input  logic [AW-1:0]    req_adr_b,
  input  logic [DW-1:0]    req_dat_a,
  input  logic [DW-1:0]    req_dat_b,
  output logic [1:0]       rsp_vld,
  output logic [DW-1:0]    rsp_dat,
  output logic             rsp_sbe,
  output logic             rsp_dbe,
  output logic             init_done,
  output logic [CNT_W-1:0] sbe_cnt,
  output logic [CNT_W-1:0] dbe_cnt,
  output logic [AW-1:0]    ram_wadr,
  output logic             ram_wen,
  output logic [DW-1:0]    ram_wdat,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_radr,
  input  logic [DW-1:0]    ram_rdat,
  input  logic             ram_rsbe,
  input  logic             ram_rdbe
);

  typedef enum logic {INIT, RUN} st_t;

  st_t               st;
  logic [AW-1:0]     init_adr;
  logic              rr_ptr;
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pid;
  logic [AW-1:0]     wadr_q;
  logic [AW-1:0]     radr_q;
  logic [DW-1:0]     wdat_q;
  logic [DW-1:0]     rdat_q;

  logic          run;
  logic          gnt_a;
  logic          gnt_b;
  logic          any;
  logic          g_we;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic          out_v;

  always_comb begin
    run   = (st == RUN);
    gnt_a = run & req_vld[0] & (~req_vld[1] | ~rr_ptr);
    gnt_b = run & req_vld[1] & (~req_vld[0] | rr_ptr);
    any   = gnt_a | gnt_b;
    g_we  = gnt_a ? req_we[0] : req_we[1];
    g_adr = gnt_a ? req_adr_a : req_adr_b;
    g_dat = gnt_a ? req_dat_a : req_dat_b;
    req_rdy = {gnt_b, gnt_a};

    // Sweep writes are masked while reset is held
    ram_wen  = (~run & rst_n) | (any & g_we);
    ram_wadr = wadr_q;
    ram_wdat = wdat_q;
    if (!run) begin
      ram_wadr = init_adr;
      ram_wdat = '0;
    end else if (any & g_we) begin
      ram_wadr = g_adr;
      ram_wdat = g_dat;
    end
    ram_ren  = any & ~g_we;
    ram_radr = ram_ren ? g_adr : radr_q;

    out_v   = pv[RD_LAT-1];
    rsp_vld = {out_v & pid[RD_LAT-1], out_v & ~pid[RD_LAT-1]};
    rsp_dat = out_v ? ram_rdat : rdat_q;
    rsp_sbe = out_v & ram_rsbe;
    rsp_dbe = out_v & ram_rdbe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= INIT;
      init_adr  <= '0;
      init_done <= 1'b0;
      rr_ptr    <= 1'b0;
      pv        <= '0;
      pid       <= '0;
      wadr_q    <= '0;
      radr_q    <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      sbe_cnt   <= '0;
      dbe_cnt   <= '0;
    end else begin
      unique case (st)
        INIT: begin
          init_adr <= init_adr + AW'(1);
          if (init_adr == '1) begin
            st        <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: init_done <= 1'b1;
        default: st <= INIT;
      endcase
      if (run && (&req_vld))
        rr_ptr <= ~rr_ptr;
      wadr_q <= ram_wadr;
      wdat_q <= ram_wdat;
      radr_q <= ram_radr;
      rdat_q <= rsp_dat;
      pv     <= (pv << 1) | RD_LAT'(ram_ren);
      pid    <= (pid << 1) | RD_LAT'(gnt_b);
      if (rsp_sbe && sbe_cnt != '1)
        sbe_cnt <= sbe_cnt + CNT_W'(1);
      if (rsp_dbe && dbe_cnt != '1)
        dbe_cnt <= dbe_cnt + CNT_W'(1);
    end
  end

endmodule
